// File: rtl/lvds_align_pkg.sv
// lvds_align_pkg: shared state encoding and parameter defaults for the
// LVDS lane alignment controller.
package lvds_align_pkg;

    localparam int unsigned DEF_NLANES        = 4;
    localparam int unsigned DEF_WIDTH         = 8;
    localparam logic [7:0]  DEF_TRAIN_PAT     = 8'h1E;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;
    localparam int unsigned DEF_MATCH_COUNT   = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
    } align_state_t;

endpackage

// File: rtl/lvds_align_lane_chk.sv
// lvds_align_lane_chk: picks the word of the lane currently being trained,
// compares it with the training pattern and counts consecutive matches.
module lvds_align_lane_chk
    import lvds_align_pkg::*;
#(
    parameter int unsigned       NLANES      = DEF_NLANES,
    parameter int unsigned       WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  TRAIN_PAT   = WIDTH'(DEF_TRAIN_PAT),
    parameter int unsigned       MATCH_COUNT = DEF_MATCH_COUNT,
    parameter int unsigned       LW          = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LW-1:0]            i_lane,
    input  logic [NLANES*WIDTH-1:0]  i_rx_data,
    input  logic                     i_clr,
    input  logic                     i_inc,
    output logic                     o_match,
    output logic                     o_done
);

    localparam int unsigned CW = $clog2(MATCH_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MATCH_COUNT - 1);

    logic [WIDTH-1:0] w_word;
    logic [CW-1:0]    r_cnt;

    // Current lane word and match decode
    always_comb begin
        w_word  = i_rx_data[i_lane*WIDTH +: WIDTH];
        o_match = (w_word == TRAIN_PAT);
        o_done  = o_match && (r_cnt == CNT_LAST);
    end

    // Consecutive-match counter; cleared whenever the lane is not being checked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && o_match && !o_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lvds_align_ctrl.sv
// lvds_align_ctrl: sequential per-lane word alignment using bitslip pulses
// against a known training pattern.
// Optional feature: define LVDS_ALIGN_STATS_EN to add the 16-bit saturating
// slip_total output counting bitslip pulses since the last start.
module lvds_align_ctrl
    import lvds_align_pkg::*;
#(
    parameter int unsigned       NLANES        = DEF_NLANES,
    parameter int unsigned       WIDTH         = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  TRAIN_PAT     = WIDTH'(DEF_TRAIN_PAT),
    parameter int unsigned       SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned       MATCH_COUNT   = DEF_MATCH_COUNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NLANES*WIDTH-1:0]  rx_data,
    output logic                     tx_train,
    output logic [NLANES-1:0]        bitslip,
    output logic                     busy,
    output logic                     locked,
    output logic                     fail,
    output logic [NLANES-1:0]        lane_ok
`ifdef LVDS_ALIGN_STATS_EN
    ,
    output logic [15:0]              slip_total
`endif
);

    localparam int unsigned LW  = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int unsigned SW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [LW-1:0]  LANE_LAST   = LW'(NLANES - 1);
    localparam logic [SW-1:0]  SLIP_LAST   = SW'(WIDTH - 1);
    localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);

    align_state_t      r_state;
    logic [LW-1:0]     r_lane;
    logic [SW-1:0]     r_slip_cnt;
    logic [STW-1:0]    r_settle_cnt;
    logic [NLANES-1:0] r_lane_ok;

    logic w_restart;
    logic w_match;
    logic w_done;
    logic w_chk_clr;
    logic w_chk_inc;

    // Start is honoured only from the resting states
    always_comb begin
        w_restart = start && ((r_state == ST_IDLE) ||
                              (r_state == ST_LOCKED) ||
                              (r_state == ST_FAIL));
        w_chk_inc = (r_state == ST_CHECK);
        w_chk_clr = (r_state != ST_CHECK);
    end

    lvds_align_lane_chk #(
        .NLANES      (NLANES),
        .WIDTH       (WIDTH),
        .TRAIN_PAT   (TRAIN_PAT),
        .MATCH_COUNT (MATCH_COUNT),
        .LW          (LW)
    ) u_lane_chk (
        .clk       (clk),
        .rst       (rst),
        .i_lane    (r_lane),
        .i_rx_data (rx_data),
        .i_clr     (w_chk_clr),
        .i_inc     (w_chk_inc),
        .o_match   (w_match),
        .o_done    (w_done)
    );

    // Alignment sequencer: settle, check, slip or advance lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lane       <= '0;
            r_slip_cnt   <= '0;
            r_settle_cnt <= '0;
            r_lane_ok    <= '0;
        end else if (w_restart) begin
            r_state      <= ST_SETTLE;
            r_lane       <= '0;
            r_slip_cnt   <= '0;
            r_settle_cnt <= '0;
            r_lane_ok    <= '0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= ST_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        if (w_done) r_state <= ST_NEXT;
                    end else if (r_slip_cnt == SLIP_LAST) begin
                        r_state <= ST_FAIL;
                    end else begin
                        r_state <= ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    r_slip_cnt <= r_slip_cnt + 1'b1;
                    r_state    <= ST_SETTLE;
                end
                ST_NEXT: begin
                    r_lane_ok[r_lane] <= 1'b1;
                    if (r_lane == LANE_LAST) begin
                        r_state <= ST_LOCKED;
                    end else begin
                        r_lane     <= r_lane + 1'b1;
                        r_slip_cnt <= '0;
                        r_state    <= ST_SETTLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded straight from state so reset clears them asynchronously
    always_comb begin
        busy     = (r_state == ST_SETTLE) || (r_state == ST_CHECK) ||
                   (r_state == ST_SLIP)   || (r_state == ST_NEXT);
        tx_train = busy;
        locked   = (r_state == ST_LOCKED);
        fail     = (r_state == ST_FAIL);
        lane_ok  = r_lane_ok;
        bitslip  = '0;
        if (r_state == ST_SLIP) bitslip[r_lane] = 1'b1;
    end

`ifdef LVDS_ALIGN_STATS_EN
    logic [15:0] r_slip_total;

    // Saturating count of bitslip pulses since the last accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slip_total <= '0;
        end else if (w_restart) begin
            r_slip_total <= '0;
        end else if ((r_state == ST_SLIP) && (r_slip_total != '1)) begin
            r_slip_total <= r_slip_total + 1'b1;
        end
    end

    always_comb slip_total = r_slip_total;
`endif

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// tb_lvds_align_ctrl: directed checks of lvds_align_ctrl with a loopback
// deserializer model (per-lane rotation, optional stuck-at-zero lane).
module tb_lvds_align_ctrl;

    localparam logic [7:0] PAT = 8'h1E;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] rx_data;
    logic        tx_train;
    logic [3:0]  bitslip;
    logic        busy;
    logic        locked;
    logic        fail;
    logic [3:0]  lane_ok;
`ifdef LVDS_ALIGN_STATS_EN
    logic [15:0] slip_total;
`endif

    int vectors = 0;
    int miscompares = 0;

    // loopback model state
    int   cfg_rot [4];
    logic force_zero [4];
    int   slip_acc [4];
    int   pulses [4];
    int   gap_err;
    int   onehot_err;
    int   cyc = 0;
    int   prev_cyc;
    logic have_prev;
    logic mon_clr = 1'b0;

    always #5 clk = ~clk;

    lvds_align_ctrl #(
        .NLANES        (4),
        .WIDTH         (8),
        .TRAIN_PAT     (PAT),
        .SETTLE_CYCLES (16),
        .MATCH_COUNT   (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .tx_train (tx_train),
        .bitslip  (bitslip),
        .busy     (busy),
        .locked   (locked),
        .fail     (fail),
        .lane_ok  (lane_ok)
`ifdef LVDS_ALIGN_STATS_EN
        ,
        .slip_total (slip_total)
`endif
    );

    function automatic logic [7:0] rotl(input logic [7:0] w, input int r);
        logic [15:0] d;
        d = {w, w} << r;
        return d[15:8];
    endfunction

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            if (force_zero[n])
                rx_data[n*8 +: 8] = 8'h00;
            else if (tx_train)
                rx_data[n*8 +: 8] = rotl(PAT, (((cfg_rot[n] - slip_acc[n]) % 8) + 8) % 8);
            else
                rx_data[n*8 +: 8] = 8'hA5;
        end
    end

    always @(posedge clk) cyc++;

    // Deserializer slip response and pulse bookkeeping, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_clr) begin
            for (int n = 0; n < 4; n++) begin
                pulses[n]   = 0;
                slip_acc[n] = 0;
            end
            gap_err    = 0;
            onehot_err = 0;
            have_prev  = 1'b0;
            prev_cyc   = 0;
        end else begin
            if ($countones(bitslip) > 1) onehot_err++;
            if (bitslip != 4'b0) begin
                // SLIP, 16 settle cycles, one failing CHECK, next SLIP
                if (have_prev && (cyc - prev_cyc != 18)) gap_err++;
                prev_cyc  = cyc;
                have_prev = 1'b1;
                for (int n = 0; n < 4; n++) begin
                    if (bitslip[n]) begin
                        pulses[n]++;
                        slip_acc[n]++;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk);
        #1 mon_clr = 1'b1;
        @(posedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // Leaves time at 1ns after the edge that sampled start
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (locked || fail) break;
        end
        check(tag, {31'b0, locked | fail}, 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cfg_rot[n]    = 0;
            force_zero[n] = 1'b0;
        end
        #12;
        check("rst_tx_train", {31'b0, tx_train}, 32'd0);
        check("rst_bitslip",  {28'b0, bitslip},  32'd0);
        check("rst_busy",     {31'b0, busy},     32'd0);
        check("rst_locked",   {31'b0, locked},   32'd0);
        check("rst_fail",     {31'b0, fail},     32'd0);
        check("rst_lane_ok",  {28'b0, lane_ok},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // aligned lanes: exact lock latency 4*(16+32+1)
        clr_mon();
        do_start();
        check("a_busy",     {31'b0, busy},     32'd1);
        check("a_tx_train", {31'b0, tx_train}, 32'd1);
        repeat (195) @(posedge clk);
        #1;
        check("a_locked_early", {31'b0, locked}, 32'd0);
        check("a_busy_early",   {31'b0, busy},   32'd1);
        @(posedge clk);
        #1;
        check("a_locked",   {31'b0, locked},   32'd1);
        check("a_busy_end", {31'b0, busy},     32'd0);
        check("a_tx_end",   {31'b0, tx_train}, 32'd0);
        check("a_lane_ok",  {28'b0, lane_ok},  32'h0000000F);
        check("a_pulses",   pulses[0] + pulses[1] + pulses[2] + pulses[3], 32'd0);

        // start after locked reruns; start while busy is ignored
        clr_mon();
        do_start();
        check("r_locked_drop", {31'b0, locked},  32'd0);
        check("r_lane_ok_clr", {28'b0, lane_ok}, 32'd0);
        check("r_busy",        {31'b0, busy},    32'd1);
        repeat (60) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (134) @(posedge clk);
        #1;
        check("r_locked_early", {31'b0, locked}, 32'd0);
        @(posedge clk);
        #1;
        check("r_locked",  {31'b0, locked},  32'd1);
        check("r_lane_ok", {28'b0, lane_ok}, 32'h0000000F);

        // lane 2 rotated by 3
        cfg_rot[2] = 3;
        clr_mon();
        do_start();
        wait_done(1000, "s_done");
        check("s_locked",    {31'b0, locked},  32'd1);
        check("s_lane_ok",   {28'b0, lane_ok}, 32'h0000000F);
        check("s_pulses2",   pulses[2], 32'd3);
        check("s_pulses_ot", pulses[0] + pulses[1] + pulses[3], 32'd0);
        check("s_gap",       gap_err, 32'd0);
        check("s_onehot",    onehot_err, 32'd0);
`ifdef LVDS_ALIGN_STATS_EN
        check("s_slip_total", {16'b0, slip_total}, 32'd3);
`endif

        // lane 1 stuck at zero: exhausts slips
        cfg_rot[2]    = 0;
        force_zero[1] = 1'b1;
        clr_mon();
        do_start();
`ifdef LVDS_ALIGN_STATS_EN
        check("f_slip_total_clr", {16'b0, slip_total}, 32'd0);
`endif
        wait_done(1500, "f_done");
        check("f_fail",      {31'b0, fail},     32'd1);
        check("f_locked",    {31'b0, locked},   32'd0);
        check("f_busy",      {31'b0, busy},     32'd0);
        check("f_tx_train",  {31'b0, tx_train}, 32'd0);
        check("f_lane_ok",   {28'b0, lane_ok},  32'h00000001);
        check("f_pulses1",   pulses[1], 32'd7);
        check("f_pulses_ot", pulses[0] + pulses[2] + pulses[3], 32'd0);
        check("f_gap",       gap_err, 32'd0);
        check("f_onehot",    onehot_err, 32'd0);
`ifdef LVDS_ALIGN_STATS_EN
        check("f_slip_total", {16'b0, slip_total}, 32'd7);
`endif

        // reset asserted during a bitslip pulse
        force_zero[1] = 1'b0;
        cfg_rot[2]    = 3;
        clr_mon();
        do_start();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (bitslip != 4'b0) break;
        end
        check("x_pulse_seen", {28'b0, bitslip}, 32'h00000004);
        rst = 1'b1;
        #1;
        check("x_bitslip",  {28'b0, bitslip}, 32'd0);
        check("x_busy",     {31'b0, busy},    32'd0);
        check("x_tx_train", {31'b0, tx_train}, 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        cfg_rot[2] = 0;
        clr_mon();
        do_start();
        check("x_lane_ok_clr", {28'b0, lane_ok}, 32'd0);
        repeat (195) @(posedge clk);
        #1;
        check("x_locked_early", {31'b0, locked}, 32'd0);
        @(posedge clk);
        #1;
        check("x_locked",  {31'b0, locked},  32'd1);
        check("x_lane_ok", {28'b0, lane_ok}, 32'h0000000F);
        check("x_pulses",  pulses[0] + pulses[1] + pulses[2] + pulses[3], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
